// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Contents: FSM state encoding, the line levels used for frame
// delimiters, the number of data bits, and a parity helper.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
// Ports:
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   i_clr   - synchronous reload to zero (used on every state entry)
//   o_cnt   - current count, 0 .. CLKS_PER_BIT-1
//   o_tc    - terminal count, high while o_cnt == CLKS_PER_BIT-1
module uart_baud_cnt #(
  parameter  int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from the byte FIFO and sends each as a
// UART frame (start, 8 data bits LSB first, optional parity, stop).
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   enable     - permits new pops; an in-flight frame always completes
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en - one-cycle pop strobe (high in POP)
//   tx         - serial line, idles high (registered)
//   busy       - high from POP through the last STOP cycle (registered)
//   tx_done    - pulse on the final cycle of the stop bit (registered)
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t           r_state, w_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [2:0]       r_bit, w_bit_next;
  logic             r_par, w_par_next;
  logic             r_tx, r_busy, r_done;
  logic             w_tx_next;
  logic             w_pop_ok;
  logic             w_clr;
  logic             w_tc;
  logic [CNT_W-1:0] w_cnt;

  assign w_pop_ok   = enable && !fifo_empty;
  assign fifo_rd_en = (r_state == POP);
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_done;

  // Reload on every state change; also held at zero while idle.
  assign w_clr = (w_next != r_state) || (r_state == IDLE);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_clr),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next       = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_par_next   = r_par;
    unique case (r_state)
      IDLE:   if (w_pop_ok) w_next = POP;
      POP:    w_next = LOAD;
      LOAD: begin
        w_shift_next = fifo_data;
        w_par_next   = parity_of(fifo_data, PARITY_ODD);
        w_bit_next   = '0;
        w_next       = START;
      end
      START:  if (w_tc) w_next = DATA;
      DATA: begin
        if (w_tc) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'(DATA_BITS - 1)) w_next = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (w_tc) w_next = STOP;
      STOP:   if (w_tc) w_next = w_pop_ok ? POP : IDLE;
      default: w_next = IDLE;
    endcase

    // Line level is registered from the next state so tx changes on the
    // same edge the state does, keeping the output glitch-free.
    unique case (w_next)
      START:   w_tx_next = START_BIT;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_par_next;
      default: w_tx_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= STOP_BIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next != IDLE);
      // Registered one cycle early so the pulse lands on the last stop cycle.
      r_done  <= (r_state == STOP) && (w_cnt == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 4.
// Three instances: no parity, even parity, odd parity; each fed by a
// small FIFO model with a registered read port.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en[3];
  logic       empty[3];
  logic [7:0] data[3];
  logic       rd[3];
  logic       txs[3];
  logic       busy[3];
  logic       done[3];

  logic [7:0] mem[3][16];
  int         wrp[3];
  int         rdp[3];
  int         pops[3];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst_n), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(data[0]),
    .fifo_rd_en(rd[0]), .tx(txs[0]), .busy(busy[0]), .tx_done(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk(clk), .rst(rst_n), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(data[1]),
    .fifo_rd_en(rd[1]), .tx(txs[1]), .busy(busy[1]), .tx_done(done[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .rst(rst_n), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(data[2]),
    .fifo_rd_en(rd[2]), .tx(txs[2]), .busy(busy[2]), .tx_done(done[2]));

  // FIFO model: write pointer owned by the stimulus, read side by this block.
  initial begin
    for (int k = 0; k < 3; k++) begin
      rdp[k]  = 0;
      pops[k] = 0;
      data[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd[k]) begin
        pops[k] <= pops[k] + 1;
        if (rdp[k] != wrp[k]) begin
          data[k] <= mem[k][rdp[k] % 16];
          rdp[k]  <= rdp[k] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) empty[k] = (rdp[k] == wrp[k]);
  end

  typedef struct {
    int          d;
    logic [7:0]  b;
    logic [10:0] exp;
    int          nbits;
    int          donecyc;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    mem[d][wrp[d] % 16] = b;
    wrp[d] = wrp[d] + 1;
  endtask

  // Returns number of negedges waited until the pop strobe is seen.
  task automatic wait_pop(input int d, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n = i + 1;
      if (rd[d]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("pop_seen_d%0d", d), 32'(ok), 1);
    chk($sformatf("pop_busy_d%0d", d), 32'(busy[d]), 1);
  endtask

  // Called just after the POP cycle's negedge; checks LOAD then every frame cycle.
  task automatic frame(input int d, input logic [10:0] exp, input int nbits,
                       input int donecyc, input int drop_at);
    @(negedge clk);
    chk("load_tx", 32'(txs[d]), 1);
    chk("load_rd", 32'(rd[d]), 0);
    for (int c = 0; c < nbits * 4; c++) begin
      @(negedge clk);
      chk($sformatf("tx_d%0d_c%0d", d, c), 32'(txs[d]), 32'(exp[c / 4]));
      chk($sformatf("done_d%0d_c%0d", d, c), 32'(done[d]), 32'(c == donecyc - 1));
      chk($sformatf("busy_d%0d_c%0d", d, c), 32'(busy[d]), 1);
      if (c == drop_at) en[d] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      wrp[k] = 0;
    end

    tbl[0] = '{d: 0, b: 8'hA5, exp: 11'b01101001010, nbits: 10, donecyc: 40};
    tbl[1] = '{d: 1, b: 8'h07, exp: 11'b11000001110, nbits: 11, donecyc: 44};
    tbl[2] = '{d: 2, b: 8'h07, exp: 11'b10000001110, nbits: 11, donecyc: 44};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tx_d%0d", k), 32'(txs[k]), 1);
      chk($sformatf("rst_busy_d%0d", k), 32'(busy[k]), 0);
      chk($sformatf("rst_done_d%0d", k), 32'(done[k]), 0);
      chk($sformatf("rst_rd_d%0d", k), 32'(rd[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames from the table.
    for (int i = 0; i < 3; i++) begin
      push(tbl[i].d, tbl[i].b);
      @(negedge clk);
      base = pops[tbl[i].d];
      en[tbl[i].d] = 1'b1;
      wait_pop(tbl[i].d, n);
      chk($sformatf("pop_latency_v%0d", i), 32'(n), 1);
      frame(tbl[i].d, tbl[i].exp, tbl[i].nbits, tbl[i].donecyc, -1);
      @(negedge clk);
      chk($sformatf("after_busy_v%0d", i), 32'(busy[tbl[i].d]), 0);
      chk($sformatf("after_tx_v%0d", i), 32'(txs[tbl[i].d]), 1);
      en[tbl[i].d] = 1'b0;
      chk($sformatf("pop_count_v%0d", i), 32'(pops[tbl[i].d] - base), 1);
    end

    // Empty FIFO with enable high: nothing moves.
    en[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk($sformatf("empty_quiet_c%0d", c), {29'd0, rd[0], txs[0], busy[0]}, 32'b010);
    end
    en[0] = 1'b0;

    // Back-to-back frames 0x00 then 0xFF.
    push(0, 8'h00);
    push(0, 8'hFF);
    @(negedge clk);
    base = pops[0];
    en[0] = 1'b1;
    wait_pop(0, n);
    frame(0, 11'b01000000000, 10, 40, -1);
    @(negedge clk);
    chk("b2b_gap1_rd", 32'(rd[0]), 1);
    chk("b2b_gap1_tx", 32'(txs[0]), 1);
    frame(0, 11'b01111111110, 10, 40, -1);
    @(negedge clk);
    chk("b2b_end_busy", 32'(busy[0]), 0);
    chk("b2b_pop_count", 32'(pops[0] - base), 2);
    en[0] = 1'b0;

    // Reset during data bit 3 of 0x3C, then 0x81 goes out intact.
    push(0, 8'h3C);
    push(0, 8'h81);
    @(negedge clk);
    en[0] = 1'b1;
    wait_pop(0, n);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 1);
    chk("pre_rst_tx_bit3", 32'(txs[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(txs[0]), 1);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_rd", 32'(rd[0]), 0);
    repeat (2) @(negedge clk);
    base = pops[0];
    rst_n = 1'b1;
    wait_pop(0, n);
    chk("post_rst_latency", 32'(n), 1);
    frame(0, 11'b01100000010, 10, 40, -1);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy[0]), 0);
    chk("post_rst_pops", 32'(pops[0] - base), 1);
    en[0] = 1'b0;

    // Enable dropped during START with two bytes queued.
    push(0, 8'h5A);
    push(0, 8'hC3);
    @(negedge clk);
    base = pops[0];
    en[0] = 1'b1;
    wait_pop(0, n);
    frame(0, 11'b01010110100, 10, 40, 0);
    @(negedge clk);
    chk("drop_busy", 32'(busy[0]), 0);
    chk("drop_tx", 32'(txs[0]), 1);
    repeat (20) @(negedge clk);
    chk("drop_pops", 32'(pops[0] - base), 1);
    chk("drop_left_in_fifo", 32'(empty[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
